// File: rtl/y86_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : y86_pkg                                                 |
// | Brief  : Shared constants, state encoding, address range helper. |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
package y86_pkg;

  localparam int INSTR_MAX_BYTES   = 10;
  localparam int DEFAULT_MEM_BYTES = 1024;
  localparam int INSTR_BITS        = INSTR_MAX_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_t;

  // Full-width comparison so large PCs never alias into the array.
  function automatic logic in_range(input logic [63:0] addr, input int unsigned mem_bytes);
    return addr < 64'(mem_bytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_byte_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : imem_byte_array                                         |
// | Brief  : Byte storage, one sync write port, 10-byte read window. |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module imem_byte_array
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [63:0]           wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [63:0]           rd_addr,
  output logic [INSTR_BITS-1:0] rd_window
);

  localparam int c_addr_w = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  logic [7:0] r_mem [MEM_BYTES];
  logic       w_base_ok;

  always_ff @(posedge clk) begin
    if (wr_en && in_range(wr_addr, MEM_BYTES)) begin
      r_mem[wr_addr[c_addr_w-1:0]] <= wr_data;
    end
  end

  // Base check also blocks 64-bit wrap of rd_addr + i back into range.
  assign w_base_ok = in_range(rd_addr, MEM_BYTES);

  generate
    for (genvar gi = 0; gi < INSTR_MAX_BYTES; gi++) begin : g_rd_byte
      logic [63:0] w_addr;
      logic        w_ok;
      assign w_addr = rd_addr + 64'(gi);
      assign w_ok   = w_base_ok && in_range(w_addr, MEM_BYTES);
      assign rd_window[gi*8 +: 8] = w_ok ? r_mem[w_addr[c_addr_w-1:0]] : 8'h00;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : imem_responder                                          |
// | Brief  : Fixed-latency instruction fetch responder with loader.  |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module imem_responder
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [63:0]           req_pc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [INSTR_BITS-1:0] rsp_bytes,
  output logic                  rsp_error,
  input  logic                  load_en,
  input  logic [63:0]           load_addr,
  input  logic [7:0]            load_data,
  output logic                  busy
);

  localparam logic [3:0] c_count_init = 4'(LATENCY - 1);
  localparam logic       c_lat_one    = (LATENCY == 1);

  resp_state_t           r_state;
  logic [3:0]            r_count;
  logic [63:0]           r_pc;
  logic [63:0]           w_rd_addr;
  logic [INSTR_BITS-1:0] w_window;
  logic                  w_pc_err;
  logic                  w_enter_resp;

  // With LATENCY==1 the capture happens on the accept edge, so read the live PC.
  assign w_rd_addr = (r_state == ST_IDLE) ? req_pc : r_pc;
  assign w_pc_err  = !in_range(w_rd_addr, MEM_BYTES);

  assign w_enter_resp = ((r_state == ST_IDLE) && req_valid && c_lat_one) ||
                        ((r_state == ST_WAIT) && (r_count == 4'd1));

  imem_byte_array #(
    .MEM_BYTES (MEM_BYTES)
  ) u_array (
    .clk       (clk),
    .wr_en     (load_en),
    .wr_addr   (load_addr),
    .wr_data   (load_data),
    .rd_addr   (w_rd_addr),
    .rd_window (w_window)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= 4'd0;
      r_pc      <= 64'd0;
      rsp_valid <= 1'b0;
      rsp_bytes <= '0;
      rsp_error <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (w_enter_resp) begin
        r_state   <= ST_RESP;
        rsp_valid <= 1'b1;
        rsp_error <= w_pc_err;
        rsp_bytes <= w_pc_err ? '0 : w_window;
        req_ready <= 1'b0;
        busy      <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_pc    <= req_pc;
            r_count <= c_count_init;
            if (!c_lat_one) begin
              r_state   <= ST_WAIT;
              req_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          r_count <= r_count - 4'd1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state   <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_imem_responder                                       |
// | Brief  : Scoreboard bench with byte-array reference model.       |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module tb_imem_responder;
  import y86_pkg::*;

  localparam int MEM = 1024;
  localparam int LAT = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, rsp_ready = 1'b0, load_en = 1'b0;
  logic [63:0] req_pc = '0, load_addr = '0;
  logic [7:0]  load_data = '0;
  logic        req_ready, rsp_valid, rsp_error, busy;
  logic [79:0] rsp_bytes;

  imem_responder #(.MEM_BYTES(MEM), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_bytes(rsp_bytes), .rsp_error(rsp_error),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [79:0] b; logic e; } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  logic [7:0]  mem_m [MEM];
  int          n_chk = 0, n_pass = 0, cyc = 0, prev_first = 0, last_first = 0;
  bit          in_rsp = 0;
  logic [79:0] last_b = '0;
  logic        last_e = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [79:0] act, input logic [79:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
  endtask

  // Reference: the window is simply ten consecutive model bytes, zero past the end.
  function automatic exp_t model_read(input logic [63:0] pc);
    exp_t r;
    r.b = '0;
    r.e = (pc >= 64'(MEM));
    if (!r.e)
      for (int i = 0; i < INSTR_MAX_BYTES; i++)
        if (pc + 64'(i) < 64'(MEM)) r.b[i*8 +: 8] = mem_m[int'(pc) + i];
    return r;
  endfunction

  task automatic drive_load(input bit en, input logic [63:0] a, input logic [7:0] d);
    load_en = en; load_addr = a; load_data = d;
    if (en && a < 64'(MEM)) mem_m[int'(a)] = d;
  endtask

  task automatic rand_load(input bit rnd, input logic [63:0] pc);
    if (!rnd) drive_load(1'b0, '0, '0);
    else case ($urandom_range(0, 3))
      0:       drive_load(1'b0, '0, '0);
      1:       drive_load(1'b1, pc + 64'($urandom_range(0, 11)), 8'($urandom));
      2:       drive_load(1'b1, 64'(MEM) + 64'($urandom_range(0, 3000)), 8'($urandom));
      default: drive_load(1'b1, 64'($urandom_range(0, MEM - 1)), 8'($urandom));
    endcase
  endtask

  task automatic do_req(input logic [63:0] pc, input int hold, input bit coll,
                        input bit rnd, input bit keep, input logic [63:0] nxt);
    int g;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 40) begin rand_load(rnd, pc); @(negedge clk); g++; end
    if (!req_ready) begin chk(1'b0, "req_ready_timeout", 80'(req_ready), 80'd1); return; end
    req_valid = 1'b1; req_pc = pc; rsp_ready = keep;
    for (int k = 0; k < LAT; k++) begin
      if (k > 0) begin
        @(negedge clk);
        req_valid = keep;
        rsp_ready = keep | (rnd & 1'($urandom));
      end
      // Capture edge ends this cycle: expectation excludes this cycle's load.
      if (k == LAT - 1) exp_q.push_back(model_read(pc));
      if (coll && k == LAT - 1) drive_load(1'b1, pc, 8'hAA);
      else rand_load(rnd, pc);
    end
    g = 0;
    @(negedge clk); rand_load(rnd, pc);
    while (!rsp_valid && g < 40) begin @(negedge clk); rand_load(rnd, pc); g++; end
    if (!rsp_valid) begin
      chk(1'b0, "rsp_valid_timeout", 80'(rsp_valid), 80'd1);
      exp_q.delete(); acc_q.delete();
      return;
    end
    for (int h = 0; h < hold; h++) begin rsp_ready = 1'b0; @(negedge clk); rand_load(rnd, pc); end
    rsp_ready = 1'b1;
    if (keep) begin req_valid = 1'b1; req_pc = nxt; end
    else begin
      @(negedge clk);
      rsp_ready = 1'b0;
      drive_load(1'b0, '0, '0);
      chk(req_ready === 1'b1, "req_ready_after_rsp", 80'(req_ready), 80'd1);
    end
  endtask

  // Monitor: timing and content of every response against the scoreboard.
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (rst_n) begin
        if (req_valid && req_ready) acc_q.push_back(cyc);
        if (rsp_valid) begin
          if (!in_rsp) begin
            in_rsp = 1;
            if (acc_q.size() == 0) chk(1'b0, "unexpected_rsp", rsp_bytes, 80'd0);
            else begin
              a = acc_q.pop_front();
              chk(cyc == a + LAT, "rsp_latency", 80'(cyc - a), 80'(LAT));
              prev_first = last_first; last_first = cyc;
            end
          end
          if (exp_q.size() == 0) chk(1'b0, "rsp_without_expect", rsp_bytes, 80'd0);
          else begin
            e = exp_q[0];
            chk(rsp_bytes === e.b, "rsp_bytes", rsp_bytes, e.b);
            chk(rsp_error === e.e, "rsp_error", 80'(rsp_error), 80'(e.e));
            chk(req_ready === 1'b0 && busy === 1'b1, "ready_busy_in_resp",
                80'({req_ready, busy}), 80'(2'b01));
            if (rsp_ready) begin
              void'(exp_q.pop_front());
              in_rsp = 0; last_b = rsp_bytes; last_e = rsp_error;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pc;
    logic [7:0]  pat [10];
    pat = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    chk(rsp_valid === 1'b0, "reset_rsp_valid", 80'(rsp_valid), 80'd0);
    chk(rsp_bytes === 80'd0, "reset_rsp_bytes", rsp_bytes, 80'd0);
    chk(rsp_error === 1'b0, "reset_rsp_error", 80'(rsp_error), 80'd0);
    chk(busy === 1'b0, "reset_busy", 80'(busy), 80'd0);
    chk(req_ready === 1'b1, "reset_req_ready", 80'(req_ready), 80'd1);
    rst_n = 1'b1;

    for (int i = 0; i < MEM; i++) begin @(negedge clk); drive_load(1'b1, 64'(i), 8'($urandom)); end
    for (int i = 0; i < 10; i++) begin @(negedge clk); drive_load(1'b1, 64'(32 + i), pat[i]); end
    for (int i = 0; i < 4; i++) begin @(negedge clk); drive_load(1'b1, 64'(1020 + i), 8'(16 * (i + 1))); end

    do_req(64'd32, 0, 0, 0, 0, '0);
    chk(last_b === 80'h0A_F230 && last_e === 1'b0, "basic_read_literal", last_b, 80'h0A_F230);

    do_req(64'd1024, 0, 0, 0, 0, '0);
    chk(last_e === 1'b1 && last_b === 80'd0, "oor_1024_literal", {last_b[78:0], last_e}, 80'd1);
    do_req(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, '0);
    do_req(64'd1020, 0, 0, 0, 0, '0);
    chk(last_b === 80'h4030_2010 && last_e === 1'b0, "partial_window_literal", last_b, 80'h4030_2010);

    do_req(64'd35, 3, 0, 0, 0, '0);

    do_req(64'd32, 0, 1, 0, 0, '0);
    chk(last_b[7:0] === 8'h30, "collision_old_byte", 80'(last_b[7:0]), 80'h30);
    do_req(64'd32, 0, 0, 0, 0, '0);
    chk(last_b[7:0] === 8'hAA, "collision_reread", 80'(last_b[7:0]), 80'hAA);

    @(negedge clk); drive_load(1'b1, 64'd2000, 8'h55);
    do_req(64'd1020, 0, 0, 0, 0, '0);
    chk(last_e === 1'b0, "load_2000_no_error", 80'(last_e), 80'd0);

    rsp_ready = 1'b1;
    do_req(64'd32, 0, 0, 0, 1, 64'd42);
    do_req(64'd42, 0, 0, 0, 0, '0);
    chk(last_first - prev_first == LAT + 1, "b2b_spacing", 80'(last_first - prev_first), 80'(LAT + 1));

    @(negedge clk); drive_load(1'b0, '0, '0);
    chk(req_ready === 1'b1, "pre_reset_ready", 80'(req_ready), 80'd1);
    req_valid = 1'b1; req_pc = 64'd100;
    @(negedge clk); req_valid = 1'b0;
    chk(busy === 1'b1, "busy_in_wait", 80'(busy), 80'd1);
    #2 rst_n = 1'b0;
    #1;
    chk(rsp_valid === 1'b0 && busy === 1'b0, "async_reset_clears", 80'({rsp_valid, busy}), 80'd0);
    chk(req_ready === 1'b1, "async_reset_ready", 80'(req_ready), 80'd1);
    exp_q.delete(); acc_q.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk(rsp_valid === 1'b0, "no_rsp_after_reset", 80'(rsp_valid), 80'd0);
    do_req(64'd32, 0, 0, 0, 0, '0);
    chk(last_b[7:0] === 8'hAA, "array_kept_over_reset", 80'(last_b[7:0]), 80'hAA);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          pc = {32'($urandom), 32'($urandom)};
          if (pc < 64'(MEM)) pc = pc + 64'(MEM);
        end
        2:       pc = 64'($urandom_range(MEM - 12, MEM - 1));
        default: pc = 64'($urandom_range(0, MEM - 1));
      endcase
      do_req(pc, $urandom_range(0, 3), 1'($urandom), 1'b1, 1'b0, '0);
    end

    repeat (5) @(negedge clk);
    chk(exp_q.size() == 0, "scoreboard_drained", 80'(exp_q.size()), 80'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
